// File: rtl/dp_bram_pkg.sv
// rtl/dp_bram_pkg.sv - shared constants and byte-lane merge helper for dp_bram
package dp_bram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_NO_CHANGE   = 2;

    localparam int READ_LATENCY = 3;

    // Widest word the merge helper handles; callers zero-extend and take the low W bits.
    localparam int MAX_W = 1024;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]   old_word,
        input logic [MAX_W-1:0]   new_word,
        input logic [MAX_W/8-1:0] be
    );
        logic [MAX_W-1:0] r;
        r = old_word;
        for (int k = 0; k < MAX_W / 8; k++) begin
            if (be[k]) begin
                r[k*8 +: 8] = new_word[k*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_bram_rd_pipe.sv
// rtl/dp_bram_rd_pipe.sv - per-port 3-stage read pipeline with read-during-write select
module dp_bram_rd_pipe
    import dp_bram_pkg::*;
#(
    parameter int W           = 128,
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter bit USE_BYTE_EN = 1'b0,
    parameter int RDW_MODE    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [W-1:0]   din,
    input  logic [W/8-1:0] be,
    input  logic [W-1:0]   mem_rd,
    output logic           s1_wr,
    output logic [AW-1:0]  s1_addr,
    output logic [W-1:0]   s1_din,
    output logic [W/8-1:0] s1_be,
    output logic [W-1:0]   dout
);

    logic [W-1:0]     s2;
    logic [W-1:0]     rd_next;
    logic [MAX_W-1:0] merged_full;
    logic             merge_unused;
    logic             in_range;

    // The array write for the stage-1 access commits on the same edge that
    // stage 2 samples mem_rd, so mem_rd is always the pre-write word.
    always_comb begin
        in_range     = (32'(s1_addr) < 32'(DEPTH));
        merged_full  = byte_merge(MAX_W'(mem_rd), MAX_W'(s1_din), (MAX_W/8)'(s1_be));
        merge_unused = ^(merged_full >> W);
        rd_next      = mem_rd;
        if (!in_range) begin
            rd_next = '0;
        end else if (s1_wr && (RDW_MODE == RDW_WRITE_FIRST)) begin
            rd_next = merged_full[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_wr   <= 1'b0;
            s1_addr <= '0;
            s1_din  <= '0;
            s1_be   <= '0;
            s2      <= '0;
            dout    <= '0;
        end else begin
            s1_wr <= en & we;
            if (en) begin
                s1_addr <= addr;
                s1_din  <= din;
                s1_be   <= USE_BYTE_EN ? be : '1;
            end
            if (!(s1_wr && (RDW_MODE == RDW_NO_CHANGE))) begin
                s2 <= rd_next;
            end
            dout <= s2;
        end
    end

endmodule

// File: rtl/dp_bram.sv
// rtl/dp_bram.sv - true dual-port block RAM, 3-cycle read latency; optional DP_BRAM_COLLISION_CHECK_EN
module dp_bram
    import dp_bram_pkg::*;
#(
    parameter int W           = 128,
    parameter int DEPTH       = 1024,
    parameter bit USE_BYTE_EN = 1'b0,
    parameter int RDW_MODE    = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_en,
    input  logic [AW-1:0]  a_addr,
    input  logic [W-1:0]   a_din,
    input  logic           a_we,
    input  logic [W/8-1:0] a_be,
    output logic [W-1:0]   a_dout,
    input  logic           b_en,
    input  logic [AW-1:0]  b_addr,
    input  logic [W-1:0]   b_din,
    input  logic           b_we,
    input  logic [W/8-1:0] b_be,
    output logic [W-1:0]   b_dout
);

    logic [W-1:0] mem [DEPTH];

    logic           a_s1_wr, b_s1_wr;
    logic [AW-1:0]  a_s1_addr, b_s1_addr;
    logic [W-1:0]   a_s1_din, b_s1_din;
    logic [W/8-1:0] a_s1_be, b_s1_be;
    logic [W-1:0]   a_mem_rd, b_mem_rd;
    logic           a_ok, b_ok;

    always_comb begin
        a_ok     = (32'(a_s1_addr) < 32'(DEPTH));
        b_ok     = (32'(b_s1_addr) < 32'(DEPTH));
        a_mem_rd = a_ok ? mem[a_s1_addr] : '0;
        b_mem_rd = b_ok ? mem[b_s1_addr] : '0;
    end

    // Writes commit one edge after capture so a same-cycle reader on the
    // other port samples the old word; B is applied last and wins per lane.
    always_ff @(posedge clk) begin
        if (a_s1_wr && a_ok) begin
            for (int k = 0; k < W / 8; k++) begin
                if (a_s1_be[k]) mem[a_s1_addr][k*8 +: 8] <= a_s1_din[k*8 +: 8];
            end
        end
        if (b_s1_wr && b_ok) begin
            for (int k = 0; k < W / 8; k++) begin
                if (b_s1_be[k]) mem[b_s1_addr][k*8 +: 8] <= b_s1_din[k*8 +: 8];
            end
        end
    end

    dp_bram_rd_pipe #(
        .W(W), .DEPTH(DEPTH), .AW(AW), .USE_BYTE_EN(USE_BYTE_EN), .RDW_MODE(RDW_MODE)
    ) u_pipe_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .we(a_we), .addr(a_addr), .din(a_din),
        .be(a_be), .mem_rd(a_mem_rd), .s1_wr(a_s1_wr), .s1_addr(a_s1_addr),
        .s1_din(a_s1_din), .s1_be(a_s1_be), .dout(a_dout)
    );

    dp_bram_rd_pipe #(
        .W(W), .DEPTH(DEPTH), .AW(AW), .USE_BYTE_EN(USE_BYTE_EN), .RDW_MODE(RDW_MODE)
    ) u_pipe_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .we(b_we), .addr(b_addr), .din(b_din),
        .be(b_be), .mem_rd(b_mem_rd), .s1_wr(b_s1_wr), .s1_addr(b_s1_addr),
        .s1_din(b_s1_din), .s1_be(b_s1_be), .dout(b_dout)
    );

`ifdef DP_BRAM_COLLISION_CHECK_EN
    always @(posedge clk) begin
        if (rst_n && a_en && b_en && (a_addr == b_addr) && (a_we || b_we)) begin
            $error("dp_bram collision %s at %0t addr %0d", (a_we && b_we) ? "WW" : "RW",
                   $time, a_addr);
        end
    end
`endif

endmodule

// File: tb/tb_dp_bram.sv
// tb/tb_dp_bram.sv - randomized self-checking bench for dp_bram against an array reference model
module tb_dp_bram;
    import dp_bram_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a_en = 0, a_we = 0, b_en = 0, b_we = 0;
    logic [9:0]   a_addr = '0, b_addr = '0;
    logic [127:0] a_din = '0, b_din = '0;
    logic [15:0]  a_be = '0, b_be = '0;
    logic [127:0] a_dout, b_dout, c_dout, d_dout;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dp_bram dut (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_addr(a_addr), .a_din(a_din), .a_we(a_we), .a_be(a_be), .a_dout(a_dout),
        .b_en(b_en), .b_addr(b_addr), .b_din(b_din), .b_we(b_we), .b_be(b_be), .b_dout(b_dout)
    );

    dp_bram #(.USE_BYTE_EN(1'b1), .RDW_MODE(0)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_addr(a_addr), .a_din(a_din), .a_we(a_we), .a_be(a_be), .a_dout(c_dout),
        .b_en(b_en), .b_addr(b_addr), .b_din(b_din), .b_we(b_we), .b_be(b_be), .b_dout(d_dout)
    );

    // Reference: ref_m for the full-word/no-change instance, ref_e for the masked/write-first one.
    logic [127:0] ref_m [1024];
    logic [127:0] ref_e [1024];
    logic [127:0] ha[$], hb[$], hc[$], hd[$];
    logic [127:0] prev_a, prev_b;
    int unsigned  a_held, b_held;

    function automatic logic [127:0] lane_merge(logic [127:0] old_w, logic [127:0] new_w,
                                                logic [15:0] be);
        logic [127:0] r = old_w;
        for (int k = 0; k < 16; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        ha.delete(); hb.delete(); hc.delete(); hd.delete();
        ha.push_back('0); hb.push_back('0); hc.push_back('0); hd.push_back('0);
        ha.push_back(ref_m[0]); hb.push_back(ref_m[0]);
        hc.push_back(ref_e[0]); hd.push_back(ref_e[0]);
        prev_a = ref_m[0]; prev_b = ref_m[0];
        a_held = 0; b_held = 0;
    endtask

    // One clock: reads see memory before this cycle's writes, then writes land (B last).
    task automatic step();
        logic [127:0] ra, rb, rc, rd;
        if (a_en) a_held = a_addr;
        if (b_en) b_held = b_addr;
        if (a_en && a_we) begin
            ra = prev_a; rc = lane_merge(ref_e[a_held], a_din, a_be);
        end else begin
            ra = ref_m[a_held]; rc = ref_e[a_held];
        end
        if (b_en && b_we) begin
            rb = prev_b; rd = lane_merge(ref_e[b_held], b_din, b_be);
        end else begin
            rb = ref_m[b_held]; rd = ref_e[b_held];
        end
        prev_a = ra; prev_b = rb;
        if (a_en && a_we) begin
            ref_m[a_held] = a_din;
            ref_e[a_held] = lane_merge(ref_e[a_held], a_din, a_be);
        end
        if (b_en && b_we) begin
            ref_m[b_held] = b_din;
            ref_e[b_held] = lane_merge(ref_e[b_held], b_din, b_be);
        end
        ha.push_back(ra); hb.push_back(rb); hc.push_back(rc); hd.push_back(rd);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(logic en, logic we, int addr, logic [127:0] din, logic [15:0] be);
        a_en = en; a_we = we; a_addr = addr[9:0]; a_din = din; a_be = be;
    endtask

    task automatic set_b(logic en, logic we, int addr, logic [127:0] din, logic [15:0] be);
        b_en = en; b_we = we; b_addr = addr[9:0]; b_din = din; b_be = be;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (a_dout !== 128'd0) begin n_bad++; $display("FAIL reset_a got=%h exp=0", a_dout); end
        n_total++; if (b_dout !== 128'd0) begin n_bad++; $display("FAIL reset_b got=%h exp=0", b_dout); end
        n_total++; if (c_dout !== 128'd0) begin n_bad++; $display("FAIL reset_c got=%h exp=0", c_dout); end
        n_total++; if (d_dout !== 128'd0) begin n_bad++; $display("FAIL reset_d got=%h exp=0", d_dout); end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 1024; i++) begin
            set_a(1, 1, i, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
            step();
        end
        set_a(0, 0, 0, '0, '0);
        repeat (3) step();
    endtask

    task automatic test_readback();
        logic [127:0] pat = {4{32'hDEADBEEF}};
        set_a(1, 1, 5, pat, 16'hFFFF); step();
        set_a(1, 0, 5, '0, '0);
        repeat (3) step();
        n_total++; if (a_dout !== pat) begin n_bad++; $display("FAIL readback_a got=%h exp=%h", a_dout, pat); end
        n_total++; if (c_dout !== pat) begin n_bad++; $display("FAIL readback_c got=%h exp=%h", c_dout, pat); end
        set_a(0, 0, 0, '0, '0);
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 64; i++) begin set_a(1, 1, i, 128'(i + 1), 16'hFFFF); step(); end
        set_a(0, 0, 0, '0, '0);
        for (int i = 0; i < 64; i++) begin
            set_b(1, 0, i, '0, '0);
            repeat (3) step();
            n_total++;
            if (b_dout !== 128'(i + 1)) begin n_bad++; $display("FAIL held_read[%0d] got=%h exp=%h", i, b_dout, 128'(i + 1)); end
        end
        for (int i = 0; i < 66; i++) begin
            if (i < 64) set_b(1, 0, i, '0, '0); else set_b(0, 0, 0, '0, '0);
            step();
            if (i >= 2) begin
                n_total++;
                if (b_dout !== 128'(i - 1)) begin n_bad++; $display("FAIL b2b_read[%0d] got=%h exp=%h", i - 2, b_dout, 128'(i - 1)); end
            end
        end
        set_b(0, 0, 0, '0, '0);
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 64; i++) begin set_a(1, 1, i, 128'((i + 1) & 1), 16'hFFFF); step(); end
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin
                set_b(1, 0, i, '0, '0);
                set_a(1, 1, 128 + i, {$urandom, $urandom, $urandom, $urandom}, 16'(($urandom)));
            end else begin
                set_b(0, 0, 0, '0, '0); set_a(0, 0, 0, '0, '0);
            end
            step();
            if (i >= 2) begin
                n_total++;
                if (b_dout !== 128'((i - 1) & 1)) begin n_bad++; $display("FAIL overlap[%0d] got=%h exp=%h", i - 2, b_dout, 128'((i - 1) & 1)); end
            end
        end
    endtask

    task automatic test_edges();
        int addrs[3] = '{0, 511, 1023};
        for (int k = 0; k < 3; k++) begin
            set_a(1, 1, addrs[k], {4{32'h11110000 | k}}, 16'hFFFF); step();
        end
        set_a(0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            set_b(1, 0, addrs[k], '0, '0);
            repeat (3) step();
            n_total++;
            if (b_dout !== {4{32'h11110000 | k}}) begin n_bad++; $display("FAIL edge_addr %0d got=%h exp=%h", addrs[k], b_dout, {4{32'h11110000 | k}}); end
        end
        set_b(0, 0, 0, '0, '0);
    endtask

    task automatic test_cross_port();
        logic [127:0] pat = {4{32'h89ABCDEF}};
        logic [127:0] old_w, new_w;
        set_a(1, 1, 301, pat, 16'hFFFF); step();
        set_a(0, 0, 0, '0, '0);
        set_b(1, 0, 301, '0, '0);
        repeat (3) step();
        n_total++; if (b_dout !== pat) begin n_bad++; $display("FAIL cross_next got=%h exp=%h", b_dout, pat); end
        old_w = ref_m[302];
        new_w = ~old_w;
        set_a(1, 1, 302, new_w, 16'hFFFF);
        set_b(1, 0, 302, '0, '0);
        step();
        set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
        repeat (2) step();
        n_total++; if (b_dout !== old_w) begin n_bad++; $display("FAIL cross_same got=%h exp=%h", b_dout, old_w); end
        repeat (2) step();
        n_total++; if (b_dout !== new_w) begin n_bad++; $display("FAIL cross_settle got=%h exp=%h", b_dout, new_w); end
    endtask

    task automatic test_mask();
        logic [127:0] full = '1;
        logic [127:0] exp_c = {120'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 8'h00};
        set_a(1, 1, 7, full, 16'hFFFF); step();
        set_a(1, 1, 7, '0, 16'h0001); step();
        set_a(1, 0, 7, '0, '0);
        repeat (3) step();
        n_total++; if (c_dout !== exp_c) begin n_bad++; $display("FAIL mask_byte0 got=%h exp=%h", c_dout, exp_c); end
        n_total++; if (a_dout !== 128'd0) begin n_bad++; $display("FAIL mask_ignored got=%h exp=0", a_dout); end
        set_a(0, 0, 0, '0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            step();
            n_total++; if (a_dout !== ha[ha.size()-READ_LATENCY]) begin n_bad++; $display("FAIL rand_a[%0d] got=%h exp=%h", i, a_dout, ha[ha.size()-READ_LATENCY]); end
            n_total++; if (b_dout !== hb[hb.size()-READ_LATENCY]) begin n_bad++; $display("FAIL rand_b[%0d] got=%h exp=%h", i, b_dout, hb[hb.size()-READ_LATENCY]); end
            n_total++; if (c_dout !== hc[hc.size()-READ_LATENCY]) begin n_bad++; $display("FAIL rand_c[%0d] got=%h exp=%h", i, c_dout, hc[hc.size()-READ_LATENCY]); end
            n_total++; if (d_dout !== hd[hd.size()-READ_LATENCY]) begin n_bad++; $display("FAIL rand_d[%0d] got=%h exp=%h", i, d_dout, hd[hd.size()-READ_LATENCY]); end
        end
        set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin set_b(1, 0, 40 + i, '0, '0); step(); end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (a_dout !== 128'd0) begin n_bad++; $display("FAIL midreset_a got=%h exp=0", a_dout); end
        n_total++; if (b_dout !== 128'd0) begin n_bad++; $display("FAIL midreset_b got=%h exp=0", b_dout); end
        n_total++; if (d_dout !== 128'd0) begin n_bad++; $display("FAIL midreset_d got=%h exp=0", d_dout); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            set_b(1, 0, 10 + i, '0, '0);
            step();
            n_total++; if (b_dout !== hb[hb.size()-READ_LATENCY]) begin n_bad++; $display("FAIL restart_b[%0d] got=%h exp=%h", i, b_dout, hb[hb.size()-READ_LATENCY]); end
        end
    endtask

    initial begin
        test_reset();
        test_readback();
        test_streaming();
        test_overlap();
        test_edges();
        test_cross_port();
        test_mask();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
